// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// The checksum feature is selected with the IMEM_ARB_CHECKSUM_EN macro.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } arb_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/imem_load_ctr.sv
// Loader bookkeeping: word counter, sticky overflow flag and, when
// IMEM_ARB_CHECKSUM_EN is defined, a wrap-around checksum of accepted words.
module imem_load_ctr #(
    parameter int ADDR_WIDTH = 10,
    parameter int LOAD_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_i,
`ifdef IMEM_ARB_CHECKSUM_EN
    input  logic [31:0]           data_i,
`endif
    input  logic                  ovf_set_i,
    output logic [ADDR_WIDTH-1:0] cnt_o,
    output logic                  full_o,
    output logic                  ovf_o,
    output logic [31:0]           chk_o
);

    // One extra bit so the counter can reach LOAD_WORDS == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(LOAD_WORDS);

    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q | ovf_set_i;
        if (acc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o  = cnt_q[ADDR_WIDTH-1:0];
    assign full_o = (cnt_q >= LIMIT);
    assign ovf_o  = ovf_q;

`ifdef IMEM_ARB_CHECKSUM_EN
    logic [31:0] chk_q, chk_d;

    // Accepts only happen in LOAD, so the sum is naturally frozen elsewhere.
    always_comb begin
        chk_d = chk_q;
        if (acc_i) begin
            chk_d = chk_q + data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_o = chk_q;
`else
    assign chk_o = '0;
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single instruction-RAM port between CPU fetch, the boot loader
// stream and debug writes. Optional checksum: define IMEM_ARB_CHECKSUM_EN.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LOAD_WORDS = 1024,
    parameter logic [31:0] NOP_WORD   = NOP_INSN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           cpu_addr,
    output logic [31:0]           cpu_data,
    output logic                  cpu_stall,
    output logic                  cpu_reset,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    output logic                  ld_overflow,
    input  logic                  dbg_valid,
    output logic                  dbg_ready,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [31:0]           dbg_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           chk_out
);

    arb_state_e            state_q, state_d;
    logic                  dbg_wr_q, dbg_wr_d;
    logic                  ld_acc, ovf_set, ld_full;
    logic [ADDR_WIDTH-1:0] ld_cnt;
    logic [ADDR_WIDTH-1:0] cpu_word;
    logic [31:0]           chk_val;

    // Byte-offset and wrap-around address bits are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_WIDTH+2], cpu_addr[1:0]};
    assign cpu_word         = cpu_addr[ADDR_WIDTH+1:2];

    imem_load_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LOAD_WORDS (LOAD_WORDS)
    ) u_load_ctr (
        .clk       (clk),
        .reset     (reset),
        .acc_i     (ld_acc),
`ifdef IMEM_ARB_CHECKSUM_EN
        .data_i    (ld_data),
`endif
        .ovf_set_i (ovf_set),
        .cnt_o     (ld_cnt),
        .full_o    (ld_full),
        .ovf_o     (ld_overflow),
        .chk_o     (chk_val)
    );

    always_comb begin
        state_d   = state_q;
        dbg_wr_d  = 1'b0;
        cpu_reset = 1'b1;
        cpu_stall = 1'b1;
        cpu_data  = NOP_WORD;
        ld_ready  = 1'b0;
        dbg_ready = 1'b0;
        mem_addr  = ld_cnt;
        mem_wen   = 1'b0;
        mem_wdata = ld_data;
        ld_acc    = 1'b0;
        ovf_set   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_LOAD: begin
                    ld_ready = !ld_full;
                    if (ld_valid) begin
                        if (!ld_full) begin
                            ld_acc  = 1'b1;
                            mem_wen = 1'b1;
                        end else begin
                            ovf_set = 1'b1;
                        end
                        // A last beat ends the load even when it is dropped.
                        if (ld_last) begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    mem_addr = '0;
                    state_d  = ST_RUN;
                end
                ST_RUN: begin
                    cpu_reset = 1'b0;
                    cpu_stall = 1'b0;
                    mem_addr  = cpu_word;
                    cpu_data  = dbg_wr_q ? NOP_WORD : mem_rdata;
                    // Debug writes steal the port; the held fetch reissues next cycle.
                    if (dbg_valid) begin
                        dbg_ready = 1'b1;
                        mem_wen   = 1'b1;
                        mem_addr  = dbg_addr;
                        mem_wdata = dbg_data;
                        cpu_stall = 1'b1;
                        dbg_wr_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            dbg_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dbg_wr_q <= dbg_wr_d;
        end
    end

    assign chk_out = reset ? 32'd0 : chk_val;

endmodule
